// File: rtl/config_loader_pkg.sv
// -----------------------------------------------------------------------------
// config_loader_pkg
//   Shared definitions for the configuration-chain loader:
//   - state_e     : loader FSM encoding (IDLE / LOAD / DONE)
//   - clog2_w     : width helper, ceil(log2(value)) with a floor of 1 bit
//   - ceil_div    : integer ceiling division used to size the word count
// -----------------------------------------------------------------------------
package config_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of bits needed to hold values 0 .. value-1 (at least 1 bit).
  // Callers pass (max_count + 1) so that max_count itself fits.
  function automatic int unsigned clog2_w(input int unsigned value);
    int unsigned width;
    width = 1;
    for (int unsigned w = 1; w < 32; w++) begin
      if ((longint'(1) << w) < longint'(value)) begin
        width = w + 1;
      end
    end
    return width;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned num,
                                           input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage : config_loader_pkg

// File: rtl/config_loader_serializer.sv
// -----------------------------------------------------------------------------
// word_serializer
//   Parallel-to-serial stage for the configuration loader: a WORD_WIDTH shift
//   register with a bits-left counter, backed by a one-entry prefetch buffer.
//   When the last bit leaves the shift register in the same cycle that a word
//   is waiting (buffered or arriving), that word takes its place at the edge,
//   so a steady source produces an unbroken bit stream.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   clear_i      in   drop any held bits and the buffered word
//   load_i       in   a new word is being handed over this cycle
//   load_data_i  in   the word being handed over
//   advance_i    in   consume the current MSB this cycle
//   has_bits_o   out  shift register holds at least one unsent bit
//   msb_o        out  current bit to send (valid when has_bits_o)
//   buf_valid_o  out  prefetch buffer is occupied
// -----------------------------------------------------------------------------
module word_serializer
  import config_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [WORD_WIDTH-1:0] load_data_i,
  input  logic                  advance_i,
  output logic                  has_bits_o,
  output logic                  msb_o,
  output logic                  buf_valid_o
);

  localparam int unsigned CNT_W = clog2_w(WORD_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_WIDTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
  logic [WORD_WIDTH-1:0] buf_q,   buf_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;
  logic                  buf_valid_q, buf_valid_d;

  logic shift_now;
  logic drains;

  assign has_bits_o  = (cnt_q != '0);
  assign msb_o       = shreg_q[WORD_WIDTH-1];
  assign buf_valid_o = buf_valid_q;

  // NOTE: every variable gets its hold value first so that no path through
  // the block leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    shreg_d     = shreg_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    buf_valid_d = buf_valid_q;

    shift_now = advance_i && has_bits_o;
    // The register is free for a new word at the next edge if it is already
    // empty, or if its final bit goes out this cycle.
    drains    = !has_bits_o || (shift_now && (cnt_q == ONE_CNT));

    if (shift_now) begin
      shreg_d = {shreg_q[WORD_WIDTH-2:0], 1'b0};
      cnt_d   = cnt_q - ONE_CNT;
    end

    if (drains) begin
      if (buf_valid_q) begin
        // Buffered word has priority; a simultaneous arrival refills the
        // buffer behind it.
        shreg_d     = buf_q;
        cnt_d       = FULL_CNT;
        buf_valid_d = load_i;
        if (load_i) begin
          buf_d = load_data_i;
        end
      end else if (load_i) begin
        shreg_d = load_data_i;
        cnt_d   = FULL_CNT;
      end
    end else if (load_i) begin
      buf_d       = load_data_i;
      buf_valid_d = 1'b1;
    end

    if (clear_i) begin
      cnt_d       = '0;
      buf_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      buf_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  // NOTE: the data registers are deliberately left out of reset; their
  // contents are never observed unless the matching count/valid bit says so.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
    buf_q   <= buf_d;
  end

endmodule : word_serializer

// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
//   Upstream feeder for the configuration shift chain. After a start request
//   it fetches ceil(CHAIN_LENGTH/WORD_WIDTH) words over a valid/ready
//   handshake and shifts exactly CHAIN_LENGTH bits, MSB of word 0 first, onto
//   the chain, then pulses done. Unused low bits of the final word are never
//   shifted. CHAIN_LENGTH must be >= 1 and WORD_WIDTH >= 2.
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous active-high reset (aborts a load)
//   start         in   begin a load; only looked at while idle
//   word_data     in   bitstream word
//   word_valid    in   word_data valid
//   word_ready    out  loader accepts a word this cycle
//   shift_enable  out  chain shift enable
//   shift_in      out  chain serial input (0 whenever shift_enable is 0)
//   busy          out  a load is in progress (LOAD or DONE)
//   done          out  one-cycle pulse after the final bit has shifted
// -----------------------------------------------------------------------------
module config_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LENGTH = 64,
  parameter int unsigned WORD_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  shift_enable,
  output logic                  shift_in,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned NUM_WORDS  = ceil_div(CHAIN_LENGTH, WORD_WIDTH);
  localparam int unsigned BIT_CNT_W  = clog2_w(CHAIN_LENGTH + 1);
  localparam int unsigned WORD_CNT_W = clog2_w(NUM_WORDS + 1);

  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(CHAIN_LENGTH - 1);
  localparam logic [WORD_CNT_W-1:0] WORD_LIM  = WORD_CNT_W'(NUM_WORDS);

  state_e                 state_q, state_d;
  logic [BIT_CNT_W-1:0]   bits_shifted_q, bits_shifted_d;
  logic [WORD_CNT_W-1:0]  words_accepted_q, words_accepted_d;

  logic in_load;
  logic xfer;
  logic ser_has_bits;
  logic ser_msb;
  logic ser_buf_valid;

  // All outputs decode registered state only; word_ready never looks at
  // word_valid, so no combinational path runs back to the source.
  assign in_load      = (state_q == ST_LOAD);
  assign word_ready   = in_load && !ser_buf_valid && (words_accepted_q < WORD_LIM);
  assign xfer         = word_valid && word_ready;
  assign shift_enable = in_load && ser_has_bits;
  assign shift_in     = shift_enable && ser_msb;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

  word_serializer #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_serializer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (!in_load),
    .load_i      (xfer),
    .load_data_i (word_data),
    .advance_i   (shift_enable),
    .has_bits_o  (ser_has_bits),
    .msb_o       (ser_msb),
    .buf_valid_o (ser_buf_valid)
  );

  always_comb begin
    state_d          = state_q;
    bits_shifted_d   = bits_shifted_q;
    words_accepted_d = words_accepted_q;

    unique case (state_q)
      ST_IDLE: begin
        bits_shifted_d   = '0;
        words_accepted_d = '0;
        if (start) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (xfer) begin
          words_accepted_d = words_accepted_q + WORD_CNT_W'(1);
        end
        if (shift_enable) begin
          bits_shifted_d = bits_shifted_q + BIT_CNT_W'(1);
          // The bit going out now is the CHAIN_LENGTH-th one; any bits
          // still held (tail of the last word) are dropped by the clear.
          if (bits_shifted_q == LAST_BIT) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      bits_shifted_q   <= '0;
      words_accepted_q <= '0;
    end else begin
      state_q          <= state_d;
      bits_shifted_q   <= bits_shifted_d;
      words_accepted_q <= words_accepted_d;
    end
  end

endmodule : config_loader

// File: tb/tb_config_loader.sv
// -----------------------------------------------------------------------------
// tb_config_loader
//   Self-checking bench for config_loader. A 40-bit / 16-bit-word instance is
//   driven from a table of load scenarios; a scoreboard queue receives the
//   expected stream bits whenever a word is handed over and is drained as the
//   DUT shifts. A 32-bit / 32-bit-word instance covers the exact-fit case.
// -----------------------------------------------------------------------------
module tb_config_loader;

  localparam int CL = 40;
  localparam int WW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [WW-1:0] word_data;
  logic          word_valid;
  logic          word_ready;
  logic          shift_enable;
  logic          shift_in;
  logic          busy;
  logic          done;

  logic          b_start;
  logic [31:0]   b_data;
  logic          b_valid;
  logic          b_ready;
  logic          b_se;
  logic          b_shift_in;
  logic          b_busy;
  logic          b_done;

  config_loader #(.CHAIN_LENGTH(CL), .WORD_WIDTH(WW)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .shift_enable (shift_enable),
    .shift_in     (shift_in),
    .busy         (busy),
    .done         (done)
  );

  config_loader #(.CHAIN_LENGTH(32), .WORD_WIDTH(32)) u_dut_fit (
    .clk          (clk),
    .rst          (rst),
    .start        (b_start),
    .word_data    (b_data),
    .word_valid   (b_valid),
    .word_ready   (b_ready),
    .shift_enable (b_se),
    .shift_in     (b_shift_in),
    .busy         (b_busy),
    .done         (b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- monitor
  logic    exp_q[$];
  int      pushed;
  int      cyc      = 0;
  int      se_cnt   = 0;
  int      xfers    = 0;
  int      first_se = -1;
  int      last_se  = -1;
  int      done_cyc = -1;
  logic [CL-1:0] chain = '0;

  always @(negedge clk) begin
    logic exp_bit;
    cyc++;
    if (rst) begin
      exp_q.delete();
      pushed = 0;
    end else begin
      if (start && !busy) begin
        exp_q.delete();
        pushed   = 0;
        se_cnt   = 0;
        xfers    = 0;
        first_se = -1;
        last_se  = -1;
      end
      if (word_valid && word_ready) begin
        xfers++;
        for (int b = WW - 1; b >= 0; b--) begin
          if (pushed < CL) begin
            exp_q.push_back(word_data[b]);
            pushed++;
          end
        end
      end
      if (shift_enable) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 64'(1), 64'(0));
        end else begin
          exp_bit = exp_q.pop_front();
          check("shift_bit", 64'(shift_in), 64'(exp_bit));
        end
        se_cnt++;
        if (first_se < 0) first_se = cyc;
        last_se = cyc;
      end else begin
        check("shift_in_idle", 64'(shift_in), 64'(0));
      end
    end
    if (shift_enable) chain = {chain[CL-2:0], shift_in};
    if (done) done_cyc = cyc;
  end

  logic [31:0] b_stream = '0;
  int          b_cnt    = 0;
  int          b_xfers  = 0;

  always @(negedge clk) begin
    if (b_start && !b_busy) begin
      b_cnt   = 0;
      b_xfers = 0;
    end
    if (b_valid && b_ready) b_xfers++;
    if (b_se) begin
      b_stream = {b_stream[30:0], b_shift_in};
      b_cnt++;
    end
  end

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int          gap;         // cycles word_valid stays low after word 0
    bit          hold_start;  // keep start high for the whole load
    int          exp_xfers;
    int          exp_shifts;
    int          exp_bubble;  // idle cycles between first and last shift
    logic [39:0] exp_chain;
  } vec_t;

  logic [WW-1:0] words [3];

  task automatic run_load(input vec_t v, input string tag);
    int idx;
    int gap_left;
    bit took;
    bit got_done;
    check({tag, "_busy_idle"}, 64'(busy), 64'(0));
    start      = 1'b1;
    word_valid = 1'b0;
    tick();
    check({tag, "_busy_load"}, 64'(busy), 64'(1));
    if (!v.hold_start) start = 1'b0;
    idx      = 0;
    gap_left = 0;
    got_done = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      word_valid = (gap_left == 0);
      word_data  = (idx < 3) ? words[idx] : 16'hDEAD;
      @(negedge clk);
      took = word_valid && word_ready;
      if (done) begin
        got_done = 1'b1;
        check({tag, "_ready_in_done"}, 64'(word_ready), 64'(0));
      end
      tick();
      if (took) begin
        idx++;
        if (idx == 1) gap_left = v.gap;
      end else if (gap_left > 0) begin
        gap_left--;
      end
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(got_done), 64'(1));
    word_valid = 1'b1;
    word_data  = 16'hBEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check({tag, "_ready_after"}, 64'(word_ready), 64'(0));
      check({tag, "_no_restart"}, 64'(busy), 64'(0));
      tick();
    end
    word_valid = 1'b0;
    check({tag, "_xfers"}, 64'(xfers), 64'(v.exp_xfers));
    check({tag, "_shifts"}, 64'(se_cnt), 64'(v.exp_shifts));
    check({tag, "_bubble"}, 64'(last_se - first_se + 1 - se_cnt), 64'(v.exp_bubble));
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(last_se + 1));
    check({tag, "_chain"}, 64'(chain), 64'(v.exp_chain));
  endtask

  // ------------------------------------------------------------------ main
  initial begin
    vec_t vecs [5];
    bit   took;
    bit   got;
    int   idx;

    vecs[0] = '{0,  1'b0, 3, 40, 0, 40'hA5C30FF012};
    vecs[1] = '{5,  1'b0, 3, 40, 0, 40'hA5C30FF012};
    vecs[2] = '{20, 1'b0, 3, 40, 5, 40'hA5C30FF012};
    vecs[3] = '{0,  1'b1, 3, 40, 0, 40'hA5C30FF012};
    vecs[4] = '{0,  1'b0, 3, 40, 0, 40'hA5C30FF012};
    words[0] = 16'hA5C3;
    words[1] = 16'h0FF0;
    words[2] = 16'h12FF;

    rst        = 1'b1;
    start      = 1'b0;
    word_data  = '0;
    word_valid = 1'b0;
    b_start    = 1'b0;
    b_data     = '0;
    b_valid    = 1'b0;
    repeat (3) tick();
    check("rst_word_ready", 64'(word_ready), 64'(0));
    check("rst_shift_en", 64'(shift_enable), 64'(0));
    check("rst_shift_in", 64'(shift_in), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      run_load(vecs[i], $sformatf("vec%0d", i));
      tick();
    end

    // Reset part-way through a load, then a clean full reload.
    start = 1'b1;
    tick();
    start = 1'b0;
    idx   = 0;
    for (int c = 0; c < 200; c++) begin
      word_valid = 1'b1;
      word_data  = words[idx];
      @(negedge clk);
      took = word_valid && word_ready;
      #1;
      if (se_cnt >= 20) break;
      tick();
      if (took && idx < 2) idx++;
    end
    check("abort_reached_20", 64'(se_cnt >= 20), 64'(1));
    @(posedge clk);
    #1;
    rst        = 1'b1;
    word_valid = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("abort_word_ready", 64'(word_ready), 64'(0));
    check("abort_shift_en", 64'(shift_enable), 64'(0));
    check("abort_shift_in", 64'(shift_in), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    tick();
    run_load(vecs[0], "after_abort");
    tick();

    // Exact-fit instance: one 32-bit word fills the whole chain.
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    b_valid = 1'b1;
    b_data  = 32'h8000_0001;
    got     = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      took = b_valid && b_ready;
      if (b_done) got = 1'b1;
      tick();
      if (took) b_data = 32'hFFFF_FFFF;
    end
    b_valid = 1'b0;
    check("fit_done_seen", 64'(got), 64'(1));
    check("fit_xfers", 64'(b_xfers), 64'(1));
    check("fit_shifts", 64'(b_cnt), 64'(32));
    check("fit_stream", 64'(b_stream), 64'(32'h8000_0001));
    repeat (2) tick();
    check("fit_idle_busy", 64'(b_busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_config_loader

// File: doc/config_loader.md
Name: config_loader

Overview:
- Upstream feeder for the configuration shift chain.
- Accepts a configuration bitstream as parallel words over a valid/ready handshake and serializes it, MSB-first, onto the chain's serial input.
- Drives the chain's shift enable for exactly CHAIN_LENGTH cycles per load, then pulses done.
- A one-entry prefetch buffer lets a continuously-valid source load the chain with no bubbles.

Parameters:
- CHAIN_LENGTH, 64: number of bits in the downstream chain; must be ≥1.
- WORD_WIDTH, 32: width of input words; must be ≥2.
- Derived localparams: NUM_WORDS = ceil(CHAIN_LENGTH/WORD_WIDTH); BIT_CNT_W = clog2(CHAIN_LENGTH+1); WORD_CNT_W = clog2(NUM_WORDS+1).

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- word_data  in  WORD_WIDTH  bitstream word.
- word_valid  in  1  word_data valid.
- word_ready  out  1  loader accepts word this cycle.
- shift_enable  out  1  to chain shift_enable.
- shift_in  out  1  to chain shift_in.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final bit is shifted.

Behaviour:
- Reset: state=IDLE; word_ready, shift_enable, shift_in, busy, done all 0; counters and buffer-valid cleared.
  - Reset mid-load aborts at the next edge; the chain keeps its partial contents unless it is reset too.
- States:
  - IDLE: start=1 → LOAD.
  - LOAD: shifting and fetching; → DONE when the CHAIN_LENGTH-th bit is shifted.
  - DONE: done=1 for one cycle → IDLE.
- start:
  - Ignored outside IDLE.
  - start held high in DONE has no effect; a new load requires start sampled in IDLE.
- Datapath: shift register (WORD_WIDTH) plus bits_left_in_word counter; prefetch buffer (WORD_WIDTH plus valid bit).
- Handshake:
  - word_ready = (state==LOAD) && !buf_valid && (words_accepted < NUM_WORDS).
  - Transfer occurs when valid && ready.
  - Words beyond NUM_WORDS are never accepted.
  - word_ready does not depend combinationally on word_valid.
- Shifting:
  - In LOAD, when the shift register holds bits, shift_enable=1 and shift_in = shift_reg[WORD_WIDTH-1]; the register then shifts left.
  - When its last bit shifts out in the same cycle a buffered word exists, the buffered word moves in at that edge, so there is no bubble.
  - If the shift register is empty and the buffer is empty, shift_enable=0 and the chain holds.
  - A word accepted while the shift register is empty (and no buffer) goes straight into the shift register.
- Bit order:
  - Stream bit n (n=0 shifted first) = word[n/WORD_WIDTH] bit (WORD_WIDTH-1 - n%WORD_WIDTH).
  - After completion, chain config_data[CHAIN_LENGTH-1-n] = stream bit n.
  - Unused low bits of the final word are discarded and never shifted.
- Counting: bits_shifted increments on every shift_enable cycle. When it reaches CHAIN_LENGTH, shift_enable is 0 from the next cycle and the state is DONE.
- Latency:
  - start in IDLE at edge k → word_ready can be high in cycle k+1.
  - A word accepted at edge t → first shift_enable in cycle t+1.
  - With word_valid held high: CHAIN_LENGTH consecutive shift_enable cycles, then done in the following cycle.
- shift_in is 0 whenever shift_enable=0.
- Outputs are registered or decoded from registered state only.

Decomposition:
- Shared package: state encoding (IDLE/LOAD/DONE) and a clog2-style width helper.
- One natural sub-module: word_serializer (shift register + prefetch buffer + bits-left counter, with a load/advance/empty interface). The FSM and bit counter stay in config_loader.

Test Plan:
- CHAIN_LENGTH=40, WORD_WIDTH=16, words 0xA5C3, 0x0FF0, 0x12FF held valid, start pulse:
  - exactly 3 transfers and exactly 40 consecutive shift_enable cycles; done one cycle after.
  - Chain config_data = 0xA5C30FF012; low byte 0xFF of word 2 never shifted.
- Same load, with word_valid low for 5 cycles before the second word:
  - shift_enable low exactly during the starvation gap; final chain contents unchanged.
  - Total shift_enable count is still 40.
- start asserted while busy, and start held high through DONE:
  - No restart, no extra transfers.
  - After IDLE, a new start reloads and produces an identical result.
- rst asserted for one cycle after 20 bits shifted:
  - Next cycle: all outputs 0 and state IDLE.
  - The following start performs a full 40-bit load from word 0.
- CHAIN_LENGTH=32, WORD_WIDTH=32 (exact fit), word 0x8000_0001:
  - 1 transfer, 32 shifts.
  - shift_in is 1 on the first and last shift cycles, 0 on all others.
- word_valid high after completion: word_ready stays 0 in DONE and IDLE, and no transfer occurs.
